// File: rtl/cfg_pkg.sv
// Shared state type, CRC constants and the bit-serial CRC step for the config chain loader.
`timescale 1ns/1ps
package cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } cfg_state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One CRC-16-CCITT step, MSB-first, for a single serial bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cfg_crc16.sv
// Bit-serial CRC-16-CCITT accumulator; clear reloads the initial value.
`timescale 1ns/1ps
module cfg_crc16
  import cfg_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, din);
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Serialises host words MSB-first onto the fabric config chain, CHAIN_LEN bits per session.
// Define CFG_READBACK_EN to add a CRC-checked rotate-readback pass after loading.
`timescale 1ns/1ps
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 256
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              config_data_out,
  output logic              config_en,
  input  logic              chain_data_in,
  output logic              cfg_active,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int NWORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int REM_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
  localparam int CNT_W    = $clog2(CHAIN_LEN + 1);
  localparam int BIT_W    = $clog2(WORD_W + 1);
  localparam int WRD_W    = $clog2(NWORDS + 1);

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [BIT_W-1:0] FULL_BITS  = BIT_W'(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BITS  = BIT_W'(REM_BITS);
  localparam logic [BIT_W-1:0] ONE_BIT    = BIT_W'(1);
  localparam logic [WRD_W-1:0] LAST_WORD  = WRD_W'(NWORDS - 1);
  localparam logic [WRD_W-1:0] ALL_WORDS  = WRD_W'(NWORDS);

  cfg_state_t        state;
  logic [WORD_W-1:0] sbuf;
  logic              full;
  logic [BIT_W-1:0]  bits_left;
  logic [WRD_W-1:0]  words_acc;
  logic [CNT_W-1:0]  shift_cnt;

  logic load_shift;
  logic last_bit;
  logic more_words;
  logic accept;
  logic last_shift;

  assign load_shift = (state == LOAD) && full;
  assign last_bit   = (bits_left == ONE_BIT);
  assign more_words = (words_acc < ALL_WORDS);
  // A new word may land in the same cycle the previous word's final bit leaves.
  assign word_ready = (state == LOAD) && more_words && (!full || last_bit);
  assign accept     = word_ready && word_valid;
  assign last_shift = load_shift && (shift_cnt == LAST_SHIFT);

`ifdef CFG_READBACK_EN
  logic        verify_shift;
  logic        crc_clear;
  logic [15:0] load_crc;
  logic [15:0] rb_crc;
  logic        error_q;

  assign verify_shift    = (state == VERIFY);
  assign crc_clear       = (state == IDLE) && start;
  assign config_en       = load_shift || verify_shift;
  // During readback the tail is fed straight back to the head so the chain rotates in place.
  assign config_data_out = verify_shift ? chain_data_in : (load_shift & sbuf[WORD_W-1]);
  assign error           = error_q;

  cfg_crc16 u_load_crc (
    .clk   (clk),
    .nrst  (nrst),
    .clear (crc_clear),
    .en    (load_shift),
    .din   (sbuf[WORD_W-1]),
    .crc   (load_crc)
  );

  cfg_crc16 u_rb_crc (
    .clk   (clk),
    .nrst  (nrst),
    .clear (crc_clear),
    .en    (verify_shift),
    .din   (chain_data_in),
    .crc   (rb_crc)
  );
`else
  logic unused_chain;

  assign unused_chain    = chain_data_in;
  assign config_en       = load_shift;
  assign config_data_out = load_shift & sbuf[WORD_W-1];
  assign error           = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      sbuf       <= '0;
      full       <= 1'b0;
      bits_left  <= '0;
      words_acc  <= '0;
      shift_cnt  <= '0;
      cfg_active <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef CFG_READBACK_EN
      error_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees the
      // pre-edge values and later assignments in the block simply take priority.
      done <= 1'b0;

      if (accept) begin
        sbuf      <= word_data;
        full      <= 1'b1;
        bits_left <= (words_acc == LAST_WORD) ? LAST_BITS : FULL_BITS;
        words_acc <= words_acc + 1'b1;
      end else if (load_shift) begin
        sbuf      <= {sbuf[WORD_W-2:0], 1'b0};
        bits_left <= bits_left - 1'b1;
        if (last_bit) full <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            cfg_active <= 1'b1;
            busy       <= 1'b1;
            full       <= 1'b0;
            bits_left  <= '0;
            words_acc  <= '0;
            shift_cnt  <= '0;
`ifdef CFG_READBACK_EN
            error_q    <= 1'b0;
`endif
          end
        end

        LOAD: begin
          if (load_shift) begin
            if (last_shift) begin
              shift_cnt <= '0;
`ifdef CFG_READBACK_EN
              state      <= VERIFY;
`else
              state      <= DONE;
              done       <= 1'b1;
              cfg_active <= 1'b0;
              busy       <= 1'b0;
`endif
            end else begin
              shift_cnt <= shift_cnt + 1'b1;
            end
          end
        end

`ifdef CFG_READBACK_EN
        VERIFY: begin
          if (shift_cnt == LAST_SHIFT) begin
            state      <= DONE;
            done       <= 1'b1;
            cfg_active <= 1'b0;
            busy       <= 1'b0;
            shift_cnt  <= '0;
            // Fold in the bit arriving this cycle so the comparison sees the final readback CRC.
            error_q    <= (load_crc != crc16_step(rb_crc, chain_data_in));
          end else begin
            shift_cnt <= shift_cnt + 1'b1;
          end
        end
`endif

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
